// File: rtl/cfu_output_packer_pkg.sv
// Shared constants and helpers for the CFU output packer: response function ids,
// the int8 range check and the status-word layout.
package cfu_output_packer_pkg;

    localparam logic [6:0] OUT_READ   = 7'd16;
    localparam logic [6:0] OUT_FLUSH  = 7'd17;
    localparam logic [6:0] OUT_CLEAR  = 7'd18;
    localparam logic [6:0] OUT_STATUS = 7'd19;

    typedef enum logic [1:0] {
        LANE_0 = 2'd0,
        LANE_1 = 2'd1,
        LANE_2 = 2'd2,
        LANE_3 = 2'd3
    } lane_e;

    // True when a signed 32-bit quantizer result fits in int8.
    function automatic logic in_range8(input logic signed [31:0] d);
        return (d >= -32'sd128) && (d <= 32'sd127);
    endfunction

    // Layout returned by OUT_STATUS: {overflow, range_err, lane_count, word_count}.
    function automatic logic [31:0] pack_status(input logic ovf, input logic rerr,
                                                input logic [1:0] lane,
                                                input logic [15:0] wc);
        return {12'd0, ovf, rerr, lane, wc};
    endfunction

endpackage

// File: rtl/cfu_word_fifo.sv
// First-word-fall-through FIFO of 32-bit words with an explicit occupancy count.
// Reads return 0 while empty; push and pop together are allowed even when full.
module cfu_word_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             i_wr_en,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_en,
    output logic [31:0]      o_rd_data,
    output logic             o_rd_valid,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_rd_en && (r_count != '0) && !clear;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_push = i_wr_en && ((r_count != FULL_CNT) || w_pop) && !clear;

    // Storage array; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word presentation, forced to zero while empty.
    always_comb begin
        if (r_count != '0) begin
            o_rd_data = r_mem[r_rd_ptr];
        end else begin
            o_rd_data = 32'd0;
        end
    end

    assign o_rd_valid = (r_count != '0);
    assign o_count    = r_count;
    assign o_full     = (r_count == FULL_CNT);

endmodule

// File: rtl/cfu_output_packer.sv
// Packs four quantized int8 results into little-endian 32-bit words and queues
// them in a FWFT FIFO for the CFU response path.
module cfu_output_packer
    import cfu_output_packer_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_valid,
    input  logic signed [31:0] in_data,
    output logic               in_ready,
    input  logic               flush,
    input  logic               rd_en,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic [CNT_W-1:0]   word_count,
    output logic [1:0]         lane_count,
    output logic               range_err,
    output logic               overflow
);

    logic [31:0] r_asm;
    logic [1:0]  r_lane;
    logic        r_range_err;
    logic        r_overflow;

    logic        w_full;
    logic        w_accept;
    logic        w_complete;
    logic        w_flush_do;
    logic        w_push;
    logic        w_ovf_evt;
    logic [31:0] w_merged;

    assign in_ready   = !w_full;
    assign w_accept   = in_valid && in_ready && !clear;
    assign w_complete = w_accept && (r_lane == LANE_3);
    // A flush pushes whatever is assembled, including a byte arriving this cycle.
    assign w_flush_do = flush && !clear && !w_full && ((r_lane != LANE_0) || w_accept);
    assign w_push     = w_complete || w_flush_do;
    assign w_ovf_evt  = !clear && ((in_valid && !in_ready) || (flush && w_full));

    // Current assembly with the accepted byte dropped into its lane.
    always_comb begin
        w_merged = r_asm;
        if (w_accept) begin
            case (r_lane)
                LANE_0:  w_merged[7:0]   = in_data[7:0];
                LANE_1:  w_merged[15:8]  = in_data[7:0];
                LANE_2:  w_merged[23:16] = in_data[7:0];
                default: w_merged[31:24] = in_data[7:0];
            endcase
        end else begin
            w_merged = r_asm;
        end
    end

    // Lane assembly register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_asm       <= 32'd0;
            r_lane      <= 2'd0;
            r_range_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_asm  <= 32'd0;
                r_lane <= 2'd0;
            end else if (w_accept) begin
                r_asm  <= w_merged;
                r_lane <= r_lane + 2'd1;
            end else begin
                r_asm  <= r_asm;
                r_lane <= r_lane;
            end
            if (w_accept && !in_range8(in_data)) begin
                r_range_err <= 1'b1;
            end
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end
        end
    end

    cfu_word_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .i_wr_en   (w_push),
        .i_wr_data (w_merged),
        .i_rd_en   (rd_en),
        .o_rd_data (rd_data),
        .o_rd_valid(rd_valid),
        .o_count   (word_count),
        .o_full    (w_full)
    );

    assign lane_count = r_lane;
    assign range_err  = r_range_err;
    assign overflow   = r_overflow;

endmodule
